// File: rtl/quad_core_processor_pkg.sv
// Shared definitions for the quad-core accumulator processor.
// Holds the width constants, the run-control encoding, the opcode map,
// the per-core FSM state type and a decode helper for instruction length.
package quad_core_processor_pkg;

    localparam int NUM_CORES = 4;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int INSTR_W   = 8;

    // Only this status value lets a core advance; anything else freezes it.
    localparam logic [1:0] STATUS_RUN = 2'b01;

    localparam logic [INSTR_W-1:0] OP_NOP   = 8'h00;
    localparam logic [INSTR_W-1:0] OP_LDI   = 8'h01;
    localparam logic [INSTR_W-1:0] OP_LDAR  = 8'h02;
    localparam logic [INSTR_W-1:0] OP_LOAD  = 8'h03;
    localparam logic [INSTR_W-1:0] OP_STORE = 8'h04;
    localparam logic [INSTR_W-1:0] OP_MVR1  = 8'h05;
    localparam logic [INSTR_W-1:0] OP_MVR2  = 8'h06;
    localparam logic [INSTR_W-1:0] OP_ADD   = 8'h07;
    localparam logic [INSTR_W-1:0] OP_SUB   = 8'h08;
    localparam logic [INSTR_W-1:0] OP_MUL   = 8'h09;
    localparam logic [INSTR_W-1:0] OP_INCAR = 8'h0A;
    localparam logic [INSTR_W-1:0] OP_ADDAR = 8'h0B;
    localparam logic [INSTR_W-1:0] OP_JMP   = 8'h0C;
    localparam logic [INSTR_W-1:0] OP_JZ    = 8'h0D;
    localparam logic [INSTR_W-1:0] OP_LDID  = 8'h0E;
    localparam logic [INSTR_W-1:0] OP_END   = 8'h0F;
    localparam logic [INSTR_W-1:0] OP_MVAR  = 8'h10;
    localparam logic [INSTR_W-1:0] OP_MVAC1 = 8'h11;
    localparam logic [INSTR_W-1:0] OP_MVAC2 = 8'h12;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_OPF  = 3'd2,
        ST_OPR  = 3'd3,
        ST_EX   = 3'd4,
        ST_MEM  = 3'd5,
        ST_HALT = 3'd6
    } core_state_e;

    // True for opcodes followed by an immediate operand byte.
    function automatic logic is_two_byte(input logic [INSTR_W-1:0] opcode);
        logic two_s;
        case (opcode)
            OP_LDI, OP_LDAR, OP_JMP, OP_JZ: two_s = 1'b1;
            default:                        two_s = 1'b0;
        endcase
        return two_s;
    endfunction

endpackage

// File: rtl/quad_core_processor_proc_core.sv
// One accumulator core of the quad-core processor.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   status            : run control, STATUS_RUN advances, anything else freezes
//   instruction       : instruction memory read data (one cycle after address)
//   dataout           : data memory read data (one cycle after address)
//   addr_instruction  : instruction address (PC)
//   addr_data         : data address (AR)
//   datain            : data memory write data (AC)
//   write_en          : data memory write strobe, EX of STORE only
//   end_bit           : registered halt flag
module proc_core
    import quad_core_processor_pkg::*;
#(
    parameter int CORE_ID = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         status,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [DATA_W-1:0]  dataout,
    output logic [ADDR_W-1:0]  addr_instruction,
    output logic [ADDR_W-1:0]  addr_data,
    output logic [DATA_W-1:0]  datain,
    output logic               write_en,
    output logic               end_bit
);

    core_state_e        state_r;
    core_state_e        state_next_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  ar_r;
    logic [DATA_W-1:0]  ac_r;
    logic [DATA_W-1:0]  r1_r;
    logic [DATA_W-1:0]  r2_r;
    logic [INSTR_W-1:0] ir_r;
    logic [INSTR_W-1:0] opnd_r;
    logic               z_r;
    logic               end_r;
    logic               run_s;
    logic [DATA_W-1:0]  ac_new_s;
    logic               ac_wr_s;
    logic               write_en_s;

    assign run_s = (status == STATUS_RUN);

    // FSM state register; a frozen core keeps its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IF;
        end else if (run_s) begin
            state_r <= state_next_s;
        end else begin
            state_r <= state_r;
        end
    end

    // FSM next-state logic; ID decodes length straight from the memory output.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IF:   state_next_s = ST_ID;
            ST_ID: begin
                if (is_two_byte(instruction)) begin
                    state_next_s = ST_OPF;
                end else begin
                    state_next_s = ST_EX;
                end
            end
            ST_OPF:  state_next_s = ST_OPR;
            ST_OPR:  state_next_s = ST_EX;
            ST_EX: begin
                if (ir_r == OP_LOAD) begin
                    state_next_s = ST_MEM;
                end else if (ir_r == OP_END) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_IF;
                end
            end
            ST_MEM:  state_next_s = ST_IF;
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_IF;
        endcase
    end

    // FSM output: strobe only while running and not being reset, so an
    // aborted STORE never reaches memory.
    always_comb begin
        write_en_s = (state_r == ST_EX) && (ir_r == OP_STORE) && run_s && !reset;
    end

    // Accumulator result of the instruction held in IR (used in EX).
    always_comb begin
        ac_new_s = ac_r;
        ac_wr_s  = 1'b0;
        case (ir_r)
            OP_LDI:   begin ac_new_s = {8'h00, opnd_r};     ac_wr_s = 1'b1; end
            OP_ADD:   begin ac_new_s = ac_r + r1_r;         ac_wr_s = 1'b1; end
            OP_SUB:   begin ac_new_s = ac_r - r1_r;         ac_wr_s = 1'b1; end
            OP_MUL:   begin ac_new_s = ac_r * r1_r;         ac_wr_s = 1'b1; end
            OP_LDID:  begin ac_new_s = DATA_W'(CORE_ID);    ac_wr_s = 1'b1; end
            OP_MVAC1: begin ac_new_s = r1_r;                ac_wr_s = 1'b1; end
            OP_MVAC2: begin ac_new_s = r2_r;                ac_wr_s = 1'b1; end
            default:  begin ac_new_s = ac_r;                ac_wr_s = 1'b0; end
        endcase
    end

    // Architectural registers: fetch, operand capture, execute and load return.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r   <= 8'd0;
            ar_r   <= 8'd0;
            ac_r   <= 16'd0;
            r1_r   <= 16'd0;
            r2_r   <= 16'd0;
            ir_r   <= 8'd0;
            opnd_r <= 8'd0;
            z_r    <= 1'b0;
            end_r  <= 1'b0;
        end else if (run_s) begin
            case (state_r)
                ST_ID: begin
                    ir_r <= instruction;
                    pc_r <= pc_r + 8'd1;
                end
                ST_OPR: begin
                    opnd_r <= instruction;
                    pc_r   <= pc_r + 8'd1;
                end
                ST_EX: begin
                    if (ac_wr_s) begin
                        ac_r <= ac_new_s;
                        z_r  <= (ac_new_s == 16'd0);
                    end
                    case (ir_r)
                        OP_LDAR:  ar_r  <= opnd_r;
                        OP_MVR1:  r1_r  <= ac_r;
                        OP_MVR2:  r2_r  <= ac_r;
                        OP_INCAR: ar_r  <= ar_r + 8'd1;
                        OP_ADDAR: ar_r  <= ar_r + ac_r[7:0];
                        OP_MVAR:  ar_r  <= ac_r[7:0];
                        OP_JMP:   pc_r  <= opnd_r;
                        OP_JZ:    if (z_r) pc_r <= opnd_r;
                        OP_END:   end_r <= 1'b1;
                        default:  ;
                    endcase
                end
                ST_MEM: begin
                    ac_r <= dataout;
                    z_r  <= (dataout == 16'd0);
                end
                default: ;
            endcase
        end
    end

    assign addr_instruction = pc_r;
    assign addr_data        = ar_r;
    assign datain           = ac_r;
    assign write_en         = write_en_s;
    assign end_bit          = end_r;

endmodule

// File: rtl/quad_core_processor.sv
// Quad-core accumulator processor: four identical proc_core instances, each
// with private instruction/data memory ports. Core index is the CORE_ID
// parameter, visible to software through LDID.
// Ports (i = 0..3): status{i}, instruction{i}, dataout{i} in;
// addr_instruction_{i}, addr_data_{i}, datain{i}, write_en{i} out;
// end_process[i] is core i's halt flag.
module quad_core_processor
    import quad_core_processor_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         status0,
    input  logic [1:0]         status1,
    input  logic [1:0]         status2,
    input  logic [1:0]         status3,
    input  logic [INSTR_W-1:0] instruction0,
    input  logic [INSTR_W-1:0] instruction1,
    input  logic [INSTR_W-1:0] instruction2,
    input  logic [INSTR_W-1:0] instruction3,
    input  logic [DATA_W-1:0]  dataout0,
    input  logic [DATA_W-1:0]  dataout1,
    input  logic [DATA_W-1:0]  dataout2,
    input  logic [DATA_W-1:0]  dataout3,
    output logic [ADDR_W-1:0]  addr_instruction_0,
    output logic [ADDR_W-1:0]  addr_instruction_1,
    output logic [ADDR_W-1:0]  addr_instruction_2,
    output logic [ADDR_W-1:0]  addr_instruction_3,
    output logic [ADDR_W-1:0]  addr_data_0,
    output logic [ADDR_W-1:0]  addr_data_1,
    output logic [ADDR_W-1:0]  addr_data_2,
    output logic [ADDR_W-1:0]  addr_data_3,
    output logic [DATA_W-1:0]  datain0,
    output logic [DATA_W-1:0]  datain1,
    output logic [DATA_W-1:0]  datain2,
    output logic [DATA_W-1:0]  datain3,
    output logic               write_en0,
    output logic               write_en1,
    output logic               write_en2,
    output logic               write_en3,
    output logic [3:0]         end_process
);

    logic end0_s, end1_s, end2_s, end3_s;

    proc_core #(.CORE_ID(0)) u_core0 (
        .clk(clk), .reset(reset), .status(status0),
        .instruction(instruction0), .dataout(dataout0),
        .addr_instruction(addr_instruction_0), .addr_data(addr_data_0),
        .datain(datain0), .write_en(write_en0), .end_bit(end0_s)
    );

    proc_core #(.CORE_ID(1)) u_core1 (
        .clk(clk), .reset(reset), .status(status1),
        .instruction(instruction1), .dataout(dataout1),
        .addr_instruction(addr_instruction_1), .addr_data(addr_data_1),
        .datain(datain1), .write_en(write_en1), .end_bit(end1_s)
    );

    proc_core #(.CORE_ID(2)) u_core2 (
        .clk(clk), .reset(reset), .status(status2),
        .instruction(instruction2), .dataout(dataout2),
        .addr_instruction(addr_instruction_2), .addr_data(addr_data_2),
        .datain(datain2), .write_en(write_en2), .end_bit(end2_s)
    );

    proc_core #(.CORE_ID(3)) u_core3 (
        .clk(clk), .reset(reset), .status(status3),
        .instruction(instruction3), .dataout(dataout3),
        .addr_instruction(addr_instruction_3), .addr_data(addr_data_3),
        .datain(datain3), .write_en(write_en3), .end_bit(end3_s)
    );

    assign end_process = {end3_s, end2_s, end1_s, end0_s};

endmodule

// File: tb/tb_quad_core_processor.sv
// Self-checking bench for quad_core_processor: external memories, an
// instruction-level reference model of all four cores, directed programs
// from the test plan plus randomized straight-line programs.
module tb_quad_core_processor;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  status [4];
    logic [7:0]  instr_q [4];
    logic [15:0] dout_q [4];
    logic [7:0]  ai [4];
    logic [7:0]  ad [4];
    logic [15:0] din [4];
    logic        we [4];
    logic [3:0]  end_process;

    always #5 clk = ~clk;

    quad_core_processor dut (
        .clk(clk), .reset(reset),
        .status0(status[0]), .status1(status[1]), .status2(status[2]), .status3(status[3]),
        .instruction0(instr_q[0]), .instruction1(instr_q[1]),
        .instruction2(instr_q[2]), .instruction3(instr_q[3]),
        .dataout0(dout_q[0]), .dataout1(dout_q[1]), .dataout2(dout_q[2]), .dataout3(dout_q[3]),
        .addr_instruction_0(ai[0]), .addr_instruction_1(ai[1]),
        .addr_instruction_2(ai[2]), .addr_instruction_3(ai[3]),
        .addr_data_0(ad[0]), .addr_data_1(ad[1]), .addr_data_2(ad[2]), .addr_data_3(ad[3]),
        .datain0(din[0]), .datain1(din[1]), .datain2(din[2]), .datain3(din[3]),
        .write_en0(we[0]), .write_en1(we[1]), .write_en2(we[2]), .write_en3(we[3]),
        .end_process(end_process)
    );

    // Memories: program image shared by all instruction ports, one data array.
    logic [7:0]  imem [256];
    logic [15:0] dmem [256];
    logic [15:0] dm_init [256];
    logic        dm_load;
    logic [25:0] wlog [$];   // {core, addr, data} for every strobed cycle
    int          wbase;

    int          cyc;
    int          end_cyc [4];
    logic        end_seen [4];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m_pc [4];
    logic [7:0]  m_ar [4];
    logic [15:0] m_ac [4];
    logic [15:0] m_r1 [4];
    logic [15:0] m_r2 [4];
    logic        m_z [4];
    logic        m_halt [4];
    int          m_cyc [4];
    logic [15:0] mdm [256];
    logic [25:0] mlog [$];

    // Synchronous-read memories with write logging.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            instr_q[i] <= imem[ai[i]];
            dout_q[i]  <= dmem[ad[i]];
        end
        if (dm_load) begin
            for (int a = 0; a < 256; a++) dmem[a] <= dm_init[a];
        end else begin
            for (int i = 0; i < 4; i++)
                if (we[i] === 1'b1) dmem[ad[i]] <= din[i];
        end
        for (int i = 0; i < 4; i++)
            if (we[i] === 1'b1) wlog.push_back({2'(i), ad[i], din[i]});
    end

    // Cycle counter since reset release.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Record the cycle on which each end bit first rises.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                end_seen[i] <= 1'b0;
                end_cyc[i]  <= -1;
            end else if (end_process[i] && !end_seen[i]) begin
                end_seen[i] <= 1'b1;
                end_cyc[i]  <= cyc;
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_imem();
        for (int a = 0; a < 256; a++) imem[a] = 8'h0F;
    endtask

    task automatic random_dm();
        for (int a = 0; a < 256; a++) dm_init[a] = 16'($urandom);
    endtask

    task automatic begin_reset();
        reset   = 1'b1;
        dm_load = 1'b1;
        for (int i = 0; i < 4; i++) status[i] = 2'b01;
        repeat (2) @(negedge clk);
        dm_load = 1'b0;
    endtask

    task automatic release_reset();
        wbase = wlog.size();
        reset = 1'b0;
    endtask

    // Instruction-level model: cores step one instruction at a time in
    // lockstep; stores of a step land after all cores executed it.
    task automatic run_model();
        logic [7:0]  op, k;
        logic [15:0] nac;
        logic        wac, all_h;
        logic [25:0] pend [$];
        for (int a = 0; a < 256; a++) mdm[a] = dm_init[a];
        mlog.delete();
        for (int c = 0; c < 4; c++) begin
            m_pc[c] = 8'd0; m_ar[c] = 8'd0; m_ac[c] = 16'd0; m_r1[c] = 16'd0;
            m_r2[c] = 16'd0; m_z[c] = 1'b0; m_halt[c] = 1'b0; m_cyc[c] = 0;
        end
        for (int step = 0; step < 4000; step++) begin
            all_h = 1'b1;
            for (int c = 0; c < 4; c++) all_h = all_h & m_halt[c];
            if (all_h) break;
            pend.delete();
            for (int c = 0; c < 4; c++) begin
                if (!m_halt[c]) begin
                    op = imem[m_pc[c]];
                    m_pc[c] = m_pc[c] + 8'd1;
                    k = 8'd0;
                    if (op inside {8'h01, 8'h02, 8'h0C, 8'h0D}) begin
                        k = imem[m_pc[c]];
                        m_pc[c] = m_pc[c] + 8'd1;
                        m_cyc[c] += 5;
                    end else if (op == 8'h03) m_cyc[c] += 4;
                    else                      m_cyc[c] += 3;
                    wac = 1'b0;
                    nac = m_ac[c];
                    case (op)
                        8'h01: begin nac = {8'h00, k}; wac = 1'b1; end
                        8'h02: m_ar[c] = k;
                        8'h03: begin nac = mdm[m_ar[c]]; wac = 1'b1; end
                        8'h04: pend.push_back({2'(c), m_ar[c], m_ac[c]});
                        8'h05: m_r1[c] = m_ac[c];
                        8'h06: m_r2[c] = m_ac[c];
                        8'h07: begin nac = m_ac[c] + m_r1[c]; wac = 1'b1; end
                        8'h08: begin nac = m_ac[c] - m_r1[c]; wac = 1'b1; end
                        8'h09: begin nac = m_ac[c] * m_r1[c]; wac = 1'b1; end
                        8'h0A: m_ar[c] = m_ar[c] + 8'd1;
                        8'h0B: m_ar[c] = m_ar[c] + m_ac[c][7:0];
                        8'h0C: m_pc[c] = k;
                        8'h0D: if (m_z[c]) m_pc[c] = k;
                        8'h0E: begin nac = 16'(c); wac = 1'b1; end
                        8'h0F: m_halt[c] = 1'b1;
                        8'h10: m_ar[c] = m_ac[c][7:0];
                        8'h11: begin nac = m_r1[c]; wac = 1'b1; end
                        8'h12: begin nac = m_r2[c]; wac = 1'b1; end
                        default: ;
                    endcase
                    if (wac) begin
                        m_ac[c] = nac;
                        m_z[c]  = (nac == 16'd0);
                    end
                end
            end
            foreach (pend[j]) begin
                mdm[pend[j][23:16]] = pend[j][15:0];
                mlog.push_back(pend[j]);
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (end_process !== 4'hF && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_value({tag, "_done"}, 32'(end_process), 32'h0000000F);
        repeat (2) @(negedge clk);
    endtask

    // Compare final registers, halt cycle and per-core write history.
    task automatic compare_run(input string tag, input int xcore, input int xcyc);
        logic [25:0] g [$];
        logic [25:0] e [$];
        for (int c = 0; c < 4; c++) begin
            check_value($sformatf("%s_c%0d_ac", tag, c), 32'(din[c]), 32'(m_ac[c]));
            check_value($sformatf("%s_c%0d_ar", tag, c), 32'(ad[c]), 32'(m_ar[c]));
            check_value($sformatf("%s_c%0d_pc", tag, c), 32'(ai[c]), 32'(m_pc[c]));
            check_value($sformatf("%s_c%0d_endcyc", tag, c), 32'(end_cyc[c]),
                        32'(m_cyc[c] + ((c == xcore) ? xcyc : 0)));
            g.delete();
            e.delete();
            for (int j = wbase; j < wlog.size(); j++)
                if (wlog[j][25:24] == 2'(c)) g.push_back(wlog[j]);
            foreach (mlog[j])
                if (mlog[j][25:24] == 2'(c)) e.push_back(mlog[j]);
            check_value($sformatf("%s_c%0d_nwr", tag, c), 32'(g.size()), 32'(e.size()));
            for (int j = 0; j < g.size() && j < e.size(); j++)
                check_value($sformatf("%s_c%0d_wr%0d", tag, c, j), 32'(g[j]), 32'(e[j]));
        end
    endtask

    task automatic load_prog1();
        clear_imem();
        imem[0] = 8'h01; imem[1] = 8'h05; imem[2] = 8'h05; imem[3] = 8'h01;
        imem[4] = 8'h07; imem[5] = 8'h09; imem[6] = 8'h02; imem[7] = 8'h20;
        imem[8] = 8'h04; imem[9] = 8'h0F;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs, we_bad, base, n, p, sel;
        logic [7:0] op;
        logic [7:0] snap_pc, snap_ar;
        logic [15:0] snap_ac;
        logic [7:0] pool [16];
        pool = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                 8'h09, 8'h0A, 8'h0B, 8'h0E, 8'h10, 8'h11, 8'h12, 8'h00};

        // Reset state and first program
        load_prog1();
        random_dm();
        dm_init[8'h20] = 16'd0;
        begin_reset();
        for (int c = 0; c < 4; c++) begin
            check_value($sformatf("rst_c%0d_ai", c), 32'(ai[c]), 32'd0);
            check_value($sformatf("rst_c%0d_ad", c), 32'(ad[c]), 32'd0);
            check_value($sformatf("rst_c%0d_din", c), 32'(din[c]), 32'd0);
            check_value($sformatf("rst_c%0d_we", c), 32'(we[c]), 32'd0);
        end
        check_value("rst_end", 32'(end_process), 32'd0);
        release_reset();
        @(negedge clk);
        for (int c = 0; c < 4; c++)
            check_value($sformatf("rst_next_c%0d_ai", c), 32'(ai[c]), 32'd0);
        run_model();
        wait_done("t1");
        compare_run("t1", -1, 0);
        check_value("t1_dm20", 32'(dmem[8'h20]), 32'd35);

        // Core index selects the loaded word
        clear_imem();
        imem[0] = 8'h0E; imem[1] = 8'h10; imem[2] = 8'h03; imem[3] = 8'h0F;
        random_dm();
        dm_init[0] = 16'd10; dm_init[1] = 16'd20; dm_init[2] = 16'd30; dm_init[3] = 16'd40;
        begin_reset();
        release_reset();
        run_model();
        wait_done("t2");
        compare_run("t2", -1, 0);
        check_value("t2_c0", 32'(din[0]), 32'd10);
        check_value("t2_c3", 32'(din[3]), 32'd40);

        // Countdown loop with JZ, then 0 - 1 wrap
        for (int it = 0; it < 2; it++) begin
            n = $urandom_range(1, 6);
            clear_imem();
            imem[0]  = 8'h01; imem[1]  = 8'h01; imem[2]  = 8'h05; imem[3]  = 8'h01;
            imem[4]  = 8'(n); imem[5]  = 8'h08; imem[6]  = 8'h0D; imem[7]  = 8'h0A;
            imem[8]  = 8'h0C; imem[9]  = 8'h05; imem[10] = 8'h08; imem[11] = 8'h02;
            imem[12] = 8'h40; imem[13] = 8'h04; imem[14] = 8'h0F;
            random_dm();
            begin_reset();
            release_reset();
            run_model();
            wait_done("t3");
            compare_run($sformatf("t3_n%0d", n), -1, 0);
            check_value("t3_wrap", 32'(din[2]), 32'h0000FFFF);
        end

        // Freeze core 1 for 20 cycles mid-program
        load_prog1();
        random_dm();
        begin_reset();
        release_reset();
        run_model();
        fs = $urandom_range(3, 8);
        repeat (fs) @(negedge clk);
        status[1] = 2'b00;
        snap_pc = ai[1]; snap_ar = ad[1]; snap_ac = din[1];
        we_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (we[1] !== 1'b0) we_bad++;
        end
        check_value("t4_we1_frozen", 32'(we_bad), 32'd0);
        check_value("t4_pc_frozen", 32'(ai[1]), 32'(snap_pc));
        check_value("t4_ar_frozen", 32'(ad[1]), 32'(snap_ar));
        check_value("t4_ac_frozen", 32'(din[1]), 32'(snap_ac));
        status[1] = 2'b01;
        wait_done("t4");
        compare_run("t4", 1, 20);

        // Reset during EX of STORE aborts the write and clears end bits
        load_prog1();
        random_dm();
        begin_reset();
        status[0] = 2'b00;
        release_reset();
        n = 0;
        while (end_process !== 4'b1110 && n < 200) begin @(negedge clk); n++; end
        check_value("t5_others_end", 32'(end_process), 32'hE);
        status[0] = 2'b01;
        n = 0;
        while (we[0] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check_value("t5_store_seen", 32'(we[0]), 32'd1);
        base = wlog.size();
        reset = 1'b1;
        #1;
        check_value("t5_we_gated", 32'({we[3], we[2], we[1], we[0]}), 32'd0);
        repeat (2) @(negedge clk);
        check_value("t5_no_write", 32'(wlog.size()), 32'(base));
        check_value("t5_end_clr", 32'(end_process), 32'd0);
        check_value("t5_pc_clr", 32'(ai[0]), 32'd0);

        // Randomized straight-line programs
        for (int it = 0; it < 3; it++) begin
            clear_imem();
            p = 0;
            for (int j = 0; j < 14; j++) begin
                sel = $urandom_range(0, 15);
                op = pool[sel];
                if (op == 8'h00 && $urandom_range(0, 1) == 1)
                    op = 8'($urandom_range(8'h13, 8'hFF));
                imem[p] = op;
                p++;
                if (op == 8'h01 || op == 8'h02) begin
                    imem[p] = 8'($urandom);
                    p++;
                end
            end
            imem[p] = 8'h0F;
            random_dm();
            begin_reset();
            release_reset();
            run_model();
            wait_done("t6");
            compare_run($sformatf("t6_%0d", it), -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
